// File: rtl/time_set_ctrl.sv
// time_set_ctrl: RUN/SET mode controller for the hour:min display.
// Passes live time through in RUN. In SET_HOUR/SET_MIN it owns the
// displayed values, steps them with wrap and auto-repeat, blinks the
// edited field, and commits the edit to the counter with a load strobe.
module time_set_ctrl #(
  parameter int P_BLINK_HALF  = 500,
  parameter int P_REPEAT_DLY  = 500,
  parameter int P_REPEAT_RATE = 100,   // must not exceed P_REPEAT_DLY
  parameter int P_TIMEOUT     = 10000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick_1ms,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [5:0] i_run_hour,
  input  logic [5:0] i_run_min,
  output logic [5:0] o_hour,
  output logic [5:0] o_min,
  output logic       o_load,
  output logic [5:0] o_load_hour,
  output logic [5:0] o_load_min,
  output logic [3:0] o_blank,
  output logic       o_set_mode
);

  // Counters only ever hold 0 .. (limit-1), so $clog2(limit) bits suffice.
  localparam int BLINK_W = (P_BLINK_HALF > 1) ? $clog2(P_BLINK_HALF) : 1;
  localparam int REP_W   = (P_REPEAT_DLY > 1) ? $clog2(P_REPEAT_DLY) : 1;
  localparam int TO_W    = (P_TIMEOUT > 1)    ? $clog2(P_TIMEOUT)    : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(P_BLINK_HALF - 1);
  localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(P_REPEAT_DLY - 1);
  // After a repeat step, restart so that the next one lands RATE ticks later.
  localparam logic [REP_W-1:0]   REP_RELOAD = REP_W'(P_REPEAT_DLY - P_REPEAT_RATE);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(P_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [5:0]         edit_hour_q, edit_hour_d;
  logic [5:0]         edit_min_q, edit_min_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               mode_prev_q, up_prev_q, down_prev_q;
  logic [5:0]         o_hour_q, o_hour_d, o_min_q, o_min_d;
  logic               o_load_q, o_load_d;
  logic [5:0]         o_load_hour_q, o_load_hour_d, o_load_min_q, o_load_min_d;
  logic [3:0]         o_blank_q, o_blank_d;
  logic               o_set_mode_q, o_set_mode_d;

  logic mode_edge, up_edge, down_edge, in_set, one_held, rep_fire, step;

  // Wrapping +/-1 inside 0..maxv.
  function automatic logic [5:0] step_val(input logic [5:0] v, input logic inc,
                                          input logic [5:0] maxv);
    if (inc) return (v == maxv) ? 6'd0 : v + 6'd1;
    else     return (v == 6'd0) ? maxv : v - 6'd1;
  endfunction

  // Next-state: edges, repeat, field editing, timeout, blink and outputs.
  always_comb begin
    state_d       = state_q;
    edit_hour_d   = edit_hour_q;
    edit_min_d    = edit_min_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    rep_cnt_d     = rep_cnt_q;
    to_cnt_d      = to_cnt_q;
    o_load_hour_d = o_load_hour_q;
    o_load_min_d  = o_load_min_q;
    rep_fire      = 1'b0;

    mode_edge = i_btn_mode & ~mode_prev_q;
    up_edge   = i_btn_up   & ~up_prev_q;
    down_edge = i_btn_down & ~down_prev_q;
    in_set    = (state_q == SET_HOUR) || (state_q == SET_MIN);
    one_held  = i_btn_up ^ i_btn_down;

    // Auto-repeat only runs while exactly one of up/down is held.
    if (!in_set || !one_held || up_edge || down_edge) begin
      rep_cnt_d = '0;
    end else if (i_tick_1ms) begin
      if (rep_cnt_q == REP_LAST) begin
        rep_fire  = 1'b1;
        rep_cnt_d = REP_RELOAD;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end

    // A mode edge takes priority over any step in the same cycle.
    step = in_set && one_held && (up_edge || down_edge || rep_fire) && !mode_edge;

    case (state_q)
      RUN: begin
        if (mode_edge) begin
          edit_hour_d = i_run_hour;
          edit_min_d  = i_run_min;
          state_d     = SET_HOUR;
        end
      end
      SET_HOUR: begin
        if (mode_edge)  state_d = SET_MIN;
        else if (step)  edit_hour_d = step_val(edit_hour_q, i_btn_up, 6'd23);
      end
      SET_MIN: begin
        if (mode_edge)  state_d = COMMIT;
        else if (step)  edit_min_d = step_val(edit_min_q, i_btn_up, 6'd59);
      end
      default: state_d = RUN;  // COMMIT lasts exactly one cycle
    endcase

    // Inactivity abort: back to RUN, edit discarded, no load.
    if (!in_set || mode_edge || up_edge || down_edge || step) begin
      to_cnt_d = '0;
    end else if (i_tick_1ms) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d = '0;
        state_d  = RUN;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    // Blink restarts visible on any step or state change.
    if ((state_d != state_q) || step ||
        !((state_d == SET_HOUR) || (state_d == SET_MIN))) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (i_tick_1ms) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    o_hour_d     = (state_d == RUN) ? i_run_hour : edit_hour_d;
    o_min_d      = (state_d == RUN) ? i_run_min  : edit_min_d;
    o_load_d     = (state_d == COMMIT);
    if (state_d == COMMIT) begin
      o_load_hour_d = edit_hour_d;
      o_load_min_d  = edit_min_d;
    end
    o_set_mode_d = (state_d == SET_HOUR) || (state_d == SET_MIN);
    o_blank_d    = 4'b0000;
    if (blink_phase_d && state_d == SET_HOUR) o_blank_d = 4'b1100;
    if (blink_phase_d && state_d == SET_MIN)  o_blank_d = 4'b0011;
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= RUN;
      edit_hour_q   <= '0;
      edit_min_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      rep_cnt_q     <= '0;
      to_cnt_q      <= '0;
      mode_prev_q   <= 1'b0;
      up_prev_q     <= 1'b0;
      down_prev_q   <= 1'b0;
      o_hour_q      <= '0;
      o_min_q       <= '0;
      o_load_q      <= 1'b0;
      o_load_hour_q <= '0;
      o_load_min_q  <= '0;
      o_blank_q     <= '0;
      o_set_mode_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      edit_hour_q   <= edit_hour_d;
      edit_min_q    <= edit_min_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      rep_cnt_q     <= rep_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mode_prev_q   <= i_btn_mode;
      up_prev_q     <= i_btn_up;
      down_prev_q   <= i_btn_down;
      o_hour_q      <= o_hour_d;
      o_min_q       <= o_min_d;
      o_load_q      <= o_load_d;
      o_load_hour_q <= o_load_hour_d;
      o_load_min_q  <= o_load_min_d;
      o_blank_q     <= o_blank_d;
      o_set_mode_q  <= o_set_mode_d;
    end
  end

  assign o_hour      = o_hour_q;
  assign o_min       = o_min_q;
  assign o_load      = o_load_q;
  assign o_load_hour = o_load_hour_q;
  assign o_load_min  = o_load_min_q;
  assign o_blank     = o_blank_q;
  assign o_set_mode  = o_set_mode_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with default timing parameters.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       b_mode = 1'b0, b_up = 1'b0, b_down = 1'b0;
  logic [5:0] run_hour = 6'd0, run_min = 6'd0;
  logic [5:0] o_hour, o_min, o_load_hour, o_load_min;
  logic       o_load, o_set_mode;
  logic [3:0] o_blank;

  int total = 0;
  int bad   = 0;
  int load_cnt = 0;
  int loads_before;

  time_set_ctrl #(
    .P_BLINK_HALF(500), .P_REPEAT_DLY(500), .P_REPEAT_RATE(100), .P_TIMEOUT(10000)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_tick_1ms(tick),
    .i_btn_mode(b_mode), .i_btn_up(b_up), .i_btn_down(b_down),
    .i_run_hour(run_hour), .i_run_min(run_min),
    .o_hour(o_hour), .o_min(o_min), .o_load(o_load),
    .o_load_hour(o_load_hour), .o_load_min(o_load_min),
    .o_blank(o_blank), .o_set_mode(o_set_mode)
  );

  always #5 clk = ~clk;

  // Count load strobes, sampled mid-cycle.
  always @(negedge clk) if (o_load === 1'b1) load_cnt++;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
  endtask

  task automatic pulse_mode(); b_mode = 1'b1; cyc(); b_mode = 1'b0; cyc(); endtask
  task automatic pulse_up();   b_up   = 1'b1; cyc(); b_up   = 1'b0; cyc(); endtask
  task automatic pulse_down(); b_down = 1'b1; cyc(); b_down = 1'b0; cyc(); endtask

  task automatic test_reset();
    cyc(); rst = 1'b1; cyc();
    total++; if ({o_hour, o_min, o_load, o_load_hour, o_load_min, o_blank, o_set_mode} !== 30'd0) begin
      $display("FAIL reset_outputs got=%h exp=0", {o_hour, o_min, o_load, o_load_hour, o_load_min, o_blank, o_set_mode}); bad++; end
    rst = 1'b0; cyc();
    total++; if (o_set_mode !== 1'b0 || o_hour !== 6'd0) begin
      $display("FAIL reset_release set_mode=%b hour=%0d exp 0/0", o_set_mode, o_hour); bad++; end
    $display("test_reset done");
  endtask

  task automatic test_enter_commit();
    run_hour = 6'd12; run_min = 6'd34; cyc(); cyc();
    total++; if (o_hour !== 6'd12 || o_min !== 6'd34 || o_set_mode !== 1'b0) begin
      $display("FAIL run_follow got=%0d:%0d sm=%b exp=12:34 sm=0", o_hour, o_min, o_set_mode); bad++; end
    pulse_up();
    total++; if (o_hour !== 6'd12 || o_set_mode !== 1'b0) begin
      $display("FAIL run_up_ignored got hour=%0d sm=%b exp 12/0", o_hour, o_set_mode); bad++; end
    loads_before = load_cnt;
    b_mode = 1'b1; cyc();
    total++; if (o_set_mode !== 1'b1 || o_hour !== 6'd12 || o_min !== 6'd34) begin
      $display("FAIL enter_set got=%0d:%0d sm=%b exp=12:34 sm=1", o_hour, o_min, o_set_mode); bad++; end
    b_mode = 1'b0; cyc();
    run_hour = 6'd5; run_min = 6'd6; cyc(); cyc();
    total++; if (o_hour !== 6'd12 || o_min !== 6'd34) begin
      $display("FAIL edit_isolated got=%0d:%0d exp=12:34", o_hour, o_min); bad++; end
    pulse_mode();
    b_mode = 1'b1; cyc();
    total++; if (o_load !== 1'b1 || o_load_hour !== 6'd12 || o_load_min !== 6'd34) begin
      $display("FAIL commit_load got load=%b %0d:%0d exp load=1 12:34", o_load, o_load_hour, o_load_min); bad++; end
    b_mode = 1'b0; cyc();
    total++; if (o_load !== 1'b0 || o_set_mode !== 1'b0 || o_hour !== 6'd5) begin
      $display("FAIL after_commit got load=%b sm=%b hour=%0d exp 0/0/5", o_load, o_set_mode, o_hour); bad++; end
    total++; if (load_cnt - loads_before !== 1) begin
      $display("FAIL load_count got=%0d exp=1", load_cnt - loads_before); bad++; end
    $display("test_enter_commit done");
  endtask

  task automatic test_wrap();
    run_hour = 6'd23; run_min = 6'd59; cyc(); cyc();
    pulse_mode();
    pulse_up();
    total++; if (o_hour !== 6'd0) begin $display("FAIL hour_up_wrap got=%0d exp=0", o_hour); bad++; end
    pulse_down();
    total++; if (o_hour !== 6'd23) begin $display("FAIL hour_down_wrap got=%0d exp=23", o_hour); bad++; end
    pulse_mode();
    pulse_up();
    total++; if (o_min !== 6'd0) begin $display("FAIL min_up_wrap got=%0d exp=0", o_min); bad++; end
    pulse_down();
    total++; if (o_min !== 6'd59) begin $display("FAIL min_down_wrap got=%0d exp=59", o_min); bad++; end
    pulse_mode();
    total++; if (o_load_hour !== 6'd23 || o_load_min !== 6'd59) begin
      $display("FAIL wrap_commit got=%0d:%0d exp=23:59", o_load_hour, o_load_min); bad++; end
    $display("test_wrap done");
  endtask

  task automatic test_repeat();
    run_hour = 6'd0; run_min = 6'd10; cyc(); cyc();
    pulse_mode(); pulse_mode();
    b_up = 1'b1; cyc();
    total++; if (o_min !== 6'd11) begin $display("FAIL rep_edge got=%0d exp=11", o_min); bad++; end
    tick_n(499);
    total++; if (o_min !== 6'd11) begin $display("FAIL rep_499 got=%0d exp=11", o_min); bad++; end
    tick_n(1);
    total++; if (o_min !== 6'd12) begin $display("FAIL rep_500 got=%0d exp=12", o_min); bad++; end
    tick_n(99);
    total++; if (o_min !== 6'd12) begin $display("FAIL rep_599 got=%0d exp=12", o_min); bad++; end
    tick_n(1);
    total++; if (o_min !== 6'd13) begin $display("FAIL rep_600 got=%0d exp=13", o_min); bad++; end
    tick_n(150);
    total++; if (o_min !== 6'd14) begin $display("FAIL rep_750 got=%0d exp=14", o_min); bad++; end
    b_up = 1'b0; cyc();
    b_up = 1'b1; b_down = 1'b1; cyc();
    tick_n(600);
    total++; if (o_min !== 6'd14) begin $display("FAIL up_down_both got=%0d exp=14", o_min); bad++; end
    b_up = 1'b0; b_down = 1'b0; cyc();
    pulse_mode();
    total++; if (o_load_hour !== 6'd0 || o_load_min !== 6'd14) begin
      $display("FAIL repeat_commit got=%0d:%0d exp=0:14", o_load_hour, o_load_min); bad++; end
    $display("test_repeat done");
  endtask

  task automatic test_blink();
    run_hour = 6'd8; run_min = 6'd0; cyc(); cyc();
    pulse_mode();
    tick_n(499);
    total++; if (o_blank !== 4'b0000) begin $display("FAIL blink_499 got=%b exp=0000", o_blank); bad++; end
    tick_n(1);
    total++; if (o_blank !== 4'b1100) begin $display("FAIL blink_500 got=%b exp=1100", o_blank); bad++; end
    tick_n(500);
    total++; if (o_blank !== 4'b0000) begin $display("FAIL blink_1000 got=%b exp=0000", o_blank); bad++; end
    tick_n(500);
    total++; if (o_blank !== 4'b1100) begin $display("FAIL blink_1500 got=%b exp=1100", o_blank); bad++; end
    b_up = 1'b1; cyc();
    total++; if (o_blank !== 4'b0000 || o_hour !== 6'd9) begin
      $display("FAIL blink_step got=%b hour=%0d exp=0000 9", o_blank, o_hour); bad++; end
    b_up = 1'b0; cyc();
    tick_n(499);
    total++; if (o_blank !== 4'b0000) begin $display("FAIL blink_restart_499 got=%b exp=0000", o_blank); bad++; end
    tick_n(1);
    total++; if (o_blank !== 4'b1100) begin $display("FAIL blink_restart_500 got=%b exp=1100", o_blank); bad++; end
    pulse_mode();
    total++; if (o_blank !== 4'b0000) begin $display("FAIL blink_field_change got=%b exp=0000", o_blank); bad++; end
    tick_n(500);
    total++; if (o_blank !== 4'b0011) begin $display("FAIL blink_min got=%b exp=0011", o_blank); bad++; end
    pulse_mode();
    total++; if (o_blank !== 4'b0000) begin $display("FAIL blink_run got=%b exp=0000", o_blank); bad++; end
    $display("test_blink done");
  endtask

  task automatic test_timeout();
    run_hour = 6'd12; run_min = 6'd0; cyc(); cyc();
    pulse_mode();
    pulse_up(); pulse_up(); pulse_up();
    total++; if (o_hour !== 6'd15) begin $display("FAIL to_edit got=%0d exp=15", o_hour); bad++; end
    loads_before = load_cnt;
    tick_n(9999);
    total++; if (o_set_mode !== 1'b1 || o_hour !== 6'd15) begin
      $display("FAIL to_9999 got sm=%b hour=%0d exp 1/15", o_set_mode, o_hour); bad++; end
    run_hour = 6'd7; run_min = 6'd45;
    tick_n(1);
    total++; if (o_set_mode !== 1'b0 || o_hour !== 6'd7 || o_min !== 6'd45) begin
      $display("FAIL to_abort got sm=%b %0d:%0d exp 0 7:45", o_set_mode, o_hour, o_min); bad++; end
    run_hour = 6'd8; cyc(); cyc();
    total++; if (o_hour !== 6'd8) begin $display("FAIL to_track got=%0d exp=8", o_hour); bad++; end
    total++; if (load_cnt !== loads_before) begin
      $display("FAIL to_no_load got=%0d exp=%0d", load_cnt, loads_before); bad++; end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_edit();
    run_hour = 6'd1; run_min = 6'd30; cyc(); cyc();
    pulse_mode(); pulse_mode();
    total++; if (o_min !== 6'd30 || o_set_mode !== 1'b1) begin
      $display("FAIL mid_setup got min=%0d sm=%b exp 30/1", o_min, o_set_mode); bad++; end
    loads_before = load_cnt;
    rst = 1'b1; #1;
    total++; if ({o_hour, o_min, o_load, o_blank, o_set_mode} !== 18'd0) begin
      $display("FAIL mid_reset_async got=%h exp=0", {o_hour, o_min, o_load, o_blank, o_set_mode}); bad++; end
    cyc(); rst = 1'b0; cyc();
    total++; if (o_set_mode !== 1'b0 || o_min !== 6'd30 || load_cnt !== loads_before) begin
      $display("FAIL mid_after got sm=%b min=%0d loads=%0d exp 0/30/%0d", o_set_mode, o_min, load_cnt, loads_before); bad++; end
    $display("test_reset_mid_edit done");
  endtask

  task automatic test_held_through_reset();
    b_mode = 1'b1; cyc();
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0; cyc();
    total++; if (o_set_mode !== 1'b1) begin
      $display("FAIL held_mode_edge got sm=%b exp=1", o_set_mode); bad++; end
    b_mode = 1'b0; cyc(); cyc();
    total++; if (o_set_mode !== 1'b1) begin
      $display("FAIL held_single_edge got sm=%b exp=1", o_set_mode); bad++; end
    $display("test_held_through_reset done");
  endtask

  initial begin
    test_reset();
    test_enter_commit();
    test_wrap();
    test_repeat();
    test_blink();
    test_timeout();
    test_reset_mid_edit();
    test_held_through_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
